// File: rtl/out_sig_pkg.sv
// Shared types and helpers for the output signature compactor (out_sig_misr).
// Holds the FSM state encoding, the default MISR polynomial/seed and the
// slice-folding function used to reduce the wide DUT output vector to one
// signature-width word.
package out_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } misr_state_e;

    localparam int unsigned DEF_DATA_W = 159;
    localparam int unsigned DEF_SIG_W  = 32;
    localparam logic [DEF_SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [DEF_SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

    // Number of signature-width slices covering the data vector; the top
    // slice is zero-padded up to FOLD_W bits.
    localparam int unsigned N_SLICES = (DEF_DATA_W + DEF_SIG_W - 1) / DEF_SIG_W;
    localparam int unsigned FOLD_W   = N_SLICES * DEF_SIG_W;

    // XOR all slices of the zero-padded data vector together.
    function automatic logic [DEF_SIG_W-1:0] fold_slices(input logic [FOLD_W-1:0] data);
        logic [DEF_SIG_W-1:0] acc;
        acc = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            acc = acc ^ data[s*DEF_SIG_W +: DEF_SIG_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/out_sig_misr_step.sv
// Combinational MISR step: folds the wide input vector into one word and
// combines it with the shifted/feedback signature.
// With OUT_SIG_MISR_XCHK_EN defined, unknown (X/Z) input bits fold as 0.
module misr_step
    import out_sig_pkg::*;
#(
    parameter int unsigned          DATA_W = DEF_DATA_W,
    parameter int unsigned          SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0]     POLY   = DEF_POLY
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [DATA_W-1:0] in_data,
    output logic [SIG_W-1:0]  next_sig
);

    logic [DATA_W-1:0] clean;
    logic [FOLD_W-1:0] padded;
    logic [SIG_W-1:0]  fold;

`ifdef OUT_SIG_MISR_XCHK_EN
    // Map every bit that is not a definite 1 (0, X or Z) to 0.
    always_comb begin
        clean = '0;
        for (int i = 0; i < DATA_W; i++) begin
            clean[i] = (in_data[i] === 1'b1);
        end
    end
`else
    assign clean = in_data;
`endif

    // Zero-pad to whole slices, fold, then apply the shift-with-feedback step.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a bit unassigned and no latch is inferred.
        padded             = '0;
        padded[DATA_W-1:0] = clean;
        fold               = fold_slices(padded);
        next_sig           = {sig[SIG_W-2:0], 1'b0}
                           ^ (sig[SIG_W-1] ? POLY : '0)
                           ^ fold;
    end

endmodule

// File: rtl/out_sig_misr.sv
// out_sig_misr: output signature compactor for the fuzz DUT.
// Folds one DATA_W-bit sample per valid cycle into a SIG_W-bit MISR, counts
// accepted samples and freezes the signature when the programmed count is
// reached or a stop is requested. Synchronous active-high reset.
// Optional feature: define OUT_SIG_MISR_XCHK_EN to enable the sticky
// unknown-input flag (x_seen); otherwise x_seen is tied to 0.
module out_sig_misr
    import out_sig_pkg::*;
#(
    parameter int unsigned      DATA_W = DEF_DATA_W,
    parameter int unsigned      SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       n_samples,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              sig_valid,
    output logic [SIG_W-1:0]  signature,
    output logic [31:0]       sample_cnt,
    output logic              x_seen
);

    misr_state_e      state, state_nxt;
    logic [31:0]      target;
    logic [31:0]      cnt_inc;
    logic [SIG_W-1:0] sig_nxt;
    logic             absorb;

    assign cnt_inc = sample_cnt + 32'd1;
    // A sample is folded only in RUN and only when no restart is pending.
    assign absorb  = (state == ST_RUN) && in_valid && !start;

    misr_step #(
        .DATA_W (DATA_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY)
    ) u_step (
        .sig      (signature),
        .in_data  (in_data),
        .next_sig (sig_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start has priority over stop and sample completion.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = (n_samples != 32'd0) ? ST_RUN : ST_DONE;
        end else begin
            unique case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_RUN: begin
                    if (stop || (in_valid && (cnt_inc == target))) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy      = (state == ST_RUN);
        sig_valid = (state == ST_DONE);
    end

    // Run datapath: target latch, signature and sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            target     <= '0;
            signature  <= SEED;
            sample_cnt <= '0;
        end else if (start) begin
            target     <= n_samples;
            signature  <= SEED;
            sample_cnt <= '0;
        end else if (absorb) begin
            signature  <= sig_nxt;
            sample_cnt <= cnt_inc;
        end
    end

`ifdef OUT_SIG_MISR_XCHK_EN
    logic x_seen_q;

    // Sticky unknown-input flag, cleared by start or reset.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            x_seen_q <= 1'b0;
        end else if (absorb && $isunknown(in_data)) begin
            x_seen_q <= 1'b1;
        end
    end

    assign x_seen = x_seen_q;
`else
    assign x_seen = 1'b0;
`endif

endmodule

// File: tb/tb_out_sig_misr.sv
// Self-checking bench for out_sig_misr. Directed runs; each run's expected
// final signature/count is pushed into a scoreboard queue when the run is
// issued, and a monitor pops and compares on every rising sig_valid.
// A second instance with SEED=0 shares the stimulus.
module tb_out_sig_misr;

    localparam int unsigned DW = 159;
    localparam logic [31:0] P  = 32'h04C11DB7;
    localparam logic [31:0] S  = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [31:0]   n_samples;
    logic          in_valid;
    logic [DW-1:0] in_data;

    logic          busy, sig_valid, x_seen;
    logic [31:0]   signature, sample_cnt;
    logic          busy0, sig_valid0, x_seen0;
    logic [31:0]   signature0, sample_cnt0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] sig;
        logic [31:0] sig0;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    out_sig_misr dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .sig_valid  (sig_valid),
        .signature  (signature),
        .sample_cnt (sample_cnt),
        .x_seen     (x_seen)
    );

    out_sig_misr #(.SEED(32'h0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy0),
        .sig_valid  (sig_valid0),
        .signature  (signature0),
        .sample_cnt (sample_cnt0),
        .x_seen     (x_seen0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference fold written as explicit slices of the padded vector.
    function automatic logic [31:0] m_fold(input logic [DW-1:0] d);
        logic [159:0] p;
        p = {1'b0, d};
        return p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96] ^ p[159:128];
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] sg, input logic [DW-1:0] d);
        logic [31:0] fb;
        fb = sg[31] ? P : 32'h0;
        return (sg << 1) ^ fb ^ m_fold(d);
    endfunction

    // Monitor: compare against the scoreboard whenever sig_valid rises.
    logic sv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sig_valid && !sv_prev) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_signature", signature, e.sig);
                check("sb_sample_cnt", sample_cnt, e.cnt);
                check("sb_signature_seed0", signature0, e.sig0);
                check("sb_sig_valid_seed0", {31'd0, sig_valid0}, 32'd1);
            end
        end
        sv_prev <= sig_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] n);
        start     = 1'b1;
        n_samples = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic sample(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] sg, input logic [31:0] sg0, input logic [31:0] c);
        exp_t e;
        e.sig  = sg;
        e.sig0 = sg0;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [DW-1:0] pa, pb, pc, pd, dx, one, b128;
        logic [159:0]  r;
        logic [31:0]   e, e0;

        pa   = {31'h1234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE};
        pb   = {31'h7FFFFFFF, 32'h00000000, 32'h80000001, 32'h13579BDF, 32'h2468ACE0};
        pc   = {31'h00000001, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h00000003};
        pd   = {31'h55555555, 32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};
        one  = '0;
        one[0] = 1'b1;
        b128 = '0;
        b128[128] = 1'b1;

        rst = 1'b1; start = 1'b0; stop = 1'b0; n_samples = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
        check("rst_signature", signature, S);
        check("rst_sample_cnt", sample_cnt, 32'd0);
        check("rst_x_seen", {31'd0, x_seen}, 32'd0);

        // Single zero sample: shifted seed xor POLY.
        push(32'hFB3EE249, 32'h0, 32'd1);
        do_start(32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_seed", signature, S);
        sample('0);
        check("t1_sig_valid", {31'd0, sig_valid}, 32'd1);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        tick();

        // Single sample with bit 0, then with bit 128 (top-slice fold).
        push(32'hFB3EE248, 32'h1, 32'd1);
        do_start(32'd1);
        sample(one);
        tick();
        push(32'hFB3EE248, 32'h1, 32'd1);
        do_start(32'd1);
        sample(b128);
        tick();

        // Four samples with in_valid gaps, then frozen for 10 valid cycles.
        e  = m_step(m_step(m_step(m_step(S, pa), pb), pc), pd);
        e0 = m_step(m_step(m_step(m_step(32'h0, pa), pb), pc), pd);
        push(e, e0, 32'd4);
        do_start(32'd4);
        sample(pa); tick();
        sample(pb); tick(); tick();
        sample(pc); tick();
        check("t4_not_done_yet", {31'd0, sig_valid}, 32'd0);
        check("t4_cnt_3", sample_cnt, 32'd3);
        sample(pd);
        check("t4_done_after_4th", {31'd0, sig_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            sample(r[DW-1:0]);
        end
        check("t4_frozen_sig", signature, e);
        check("t4_frozen_cnt", sample_cnt, 32'd4);

        // Early stop on the third valid sample; that sample is absorbed.
        e  = m_step(m_step(m_step(S, pc), pa), pd);
        e0 = m_step(m_step(m_step(32'h0, pc), pa), pd);
        push(e, e0, 32'd3);
        do_start(32'd100);
        sample(pc);
        sample(pa);
        stop = 1'b1;
        sample(pd);
        stop = 1'b0;
        check("t5_done", {31'd0, sig_valid}, 32'd1);
        check("t5_cnt", sample_cnt, 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_stop_in_done", {31'd0, sig_valid}, 32'd1);
        check("t5_sig_after_stop", signature, e);

        // Restart mid-run discards the concurrent sample, then reset mid-run.
        do_start(32'd10);
        sample(pa);
        sample(pb);
        start = 1'b1; n_samples = 32'd5; in_valid = 1'b1; in_data = pc;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("t6_restart_seed", signature, S);
        check("t6_restart_cnt", sample_cnt, 32'd0);
        check("t6_restart_busy", {31'd0, busy}, 32'd1);
        sample(pd);
        check("t6_cnt_1", sample_cnt, 32'd1);
        check("t6_sig_1", signature, m_step(S, pd));
        rst = 1'b1; in_valid = 1'b1; in_data = pa;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_sig_valid", {31'd0, sig_valid}, 32'd0);
        check("t6_rst_signature", signature, S);
        check("t6_rst_cnt", sample_cnt, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_stop_in_idle", {30'd0, busy, sig_valid}, 32'd0);

        // Zero-length run from IDLE.
        push(S, 32'h0, 32'd0);
        do_start(32'd0);
        check("t7_zero_len_done", {31'd0, sig_valid}, 32'd1);
        check("t7_zero_len_busy", {31'd0, busy}, 32'd0);
        tick();

        // Unknown bit on a valid cycle.
        do_start(32'd3);
        dx = pa;
        dx[7] = 1'bx;
        sample(dx);
`ifdef OUT_SIG_MISR_XCHK_EN
        check("t8_x_seen_set", {31'd0, x_seen}, 32'd1);
        sample(pb);
        check("t8_x_seen_sticky", {31'd0, x_seen}, 32'd1);
`else
        check("t8_x_seen_off", {31'd0, x_seen}, 32'd0);
        sample(pb);
        check("t8_x_seen_off2", {31'd0, x_seen}, 32'd0);
`endif
        do_start(32'd3);
        check("t8_x_seen_cleared", {31'd0, x_seen}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
